// File: rtl/minimig_autoconfig_ctrl.sv
// rtl/minimig_autoconfig_ctrl.sv - autoconfig chain controller (Z2, Z3 x3, Ethernet under MINIMIG_AUTOCONFIG_ETH_EN)
module minimig_autoconfig_ctrl #(
    parameter int ROM_LAT = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic        rw,
    input  logic [6:0]  reg_addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        ack,
    output logic [8:0]  rom_a,
    input  logic [3:0]  rom_q,
    input  logic        z2_en,
    input  logic        z3_en,
    input  logic        z3b_en,
    input  logic        z3c_en,
    output logic [7:0]  z2_base,
    output logic [15:0] z3_base,
    output logic [15:0] z3b_base,
    output logic [15:0] z3c_base,
    output logic [15:0] eth_base,
    output logic [4:0]  cfg_valid,
    output logic [2:0]  board,
    output logic        done
);

    localparam logic [2:0] S_INIT    = 3'd0;
    localparam logic [2:0] S_IDLE    = 3'd1;
    localparam logic [2:0] S_RD_WAIT = 3'd2;
    localparam logic [2:0] S_ACK     = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [2:0] BOARD_END = 3'd7;
    localparam logic [1:0] LAT       = 2'(ROM_LAT);

    // register offsets with address bit 0 dropped
    localparam logic [5:0] OFF_BASE_Z3 = 6'h22;
    localparam logic [5:0] OFF_BASE_Z2 = 6'h24;
    localparam logic [5:0] OFF_SHUTUP  = 6'h26;

`ifdef MINIMIG_AUTOCONFIG_ETH_EN
    localparam logic ETH_PRESENT = 1'b1;
`else
    localparam logic ETH_PRESENT = 1'b0;
`endif

    logic [2:0]  state_q, state_d;
    logic [2:0]  board_q, board_d;
    logic [8:0]  rom_a_q, rom_a_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [15:0] data_out_q, data_out_d;
    logic        ack_q, ack_d;
    logic        done_q, done_d;
    logic [7:0]  z2_base_q, z2_base_d;
    logic [15:0] z3_base_q, z3_base_d;
    logic [15:0] z3b_base_q, z3b_base_d;
    logic [15:0] z3c_base_q, z3c_base_d;
    logic [3:0]  valid_q, valid_d;
`ifdef MINIMIG_AUTOCONFIG_ETH_EN
    logic [15:0] eth_base_q, eth_base_d;
    logic        eth_valid_q, eth_valid_d;
`endif

    logic [4:0] en_vec;
    logic [5:0] offset;
    logic       advance;
    logic [2:0] next_b;
    logic       unused_addr_bit;

    assign en_vec          = {ETH_PRESENT, z3c_en, z3b_en, z3_en, z2_en};
    assign offset          = reg_addr[6:1];
    assign unused_addr_bit = reg_addr[0];

    // lowest enabled board above cur (or from 0 when from_start), else end marker
    function automatic logic [2:0] pick_board(input logic [2:0] cur, input logic from_start,
                                              input logic [4:0] en);
        logic [2:0] nb;
        nb = BOARD_END;
        for (int i = 4; i >= 0; i--) begin
            if (en[i] && (from_start || (3'(i) > cur))) begin
                nb = 3'(i);
            end
        end
        return nb;
    endfunction

    always_comb begin
        state_d    = state_q;
        board_d    = board_q;
        rom_a_d    = rom_a_q;
        cnt_d      = cnt_q;
        data_out_d = data_out_q;
        ack_d      = 1'b0;
        done_d     = done_q;
        z2_base_d  = z2_base_q;
        z3_base_d  = z3_base_q;
        z3b_base_d = z3b_base_q;
        z3c_base_d = z3c_base_q;
        valid_d    = valid_q;
`ifdef MINIMIG_AUTOCONFIG_ETH_EN
        eth_base_d  = eth_base_q;
        eth_valid_d = eth_valid_q;
`endif
        advance = 1'b0;
        next_b  = BOARD_END;

        case (state_q)
            S_INIT: begin
                next_b  = pick_board(3'd0, 1'b1, en_vec);
                board_d = next_b;
                if (next_b == BOARD_END) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_IDLE: begin
                if (req) begin
                    if (rw) begin
                        rom_a_d = {board_q, offset};
                        cnt_d   = LAT;
                        state_d = S_RD_WAIT;
                    end else begin
                        ack_d   = 1'b1;
                        state_d = S_ACK;
                        if (offset == OFF_BASE_Z2 && board_q == 3'd0) begin
                            z2_base_d  = data_in[15:8];
                            valid_d[0] = 1'b1;
                            advance    = 1'b1;
                        end else if (offset == OFF_BASE_Z3 && board_q != 3'd0) begin
                            advance = 1'b1;
                            case (board_q)
                                3'd1: begin
                                    z3_base_d  = data_in;
                                    valid_d[1] = 1'b1;
                                end
                                3'd2: begin
                                    z3b_base_d = data_in;
                                    valid_d[2] = 1'b1;
                                end
                                3'd3: begin
                                    z3c_base_d = data_in;
                                    valid_d[3] = 1'b1;
                                end
`ifdef MINIMIG_AUTOCONFIG_ETH_EN
                                3'd4: begin
                                    eth_base_d  = data_in;
                                    eth_valid_d = 1'b1;
                                end
`endif
                                default: advance = 1'b0;
                            endcase
                        end else if (offset == OFF_SHUTUP) begin
                            advance = 1'b1;
                        end

                        if (advance) begin
                            next_b  = pick_board(board_q, 1'b0, en_vec);
                            board_d = next_b;
                            if (next_b == BOARD_END) begin
                                done_d  = 1'b1;
                                state_d = S_DONE;
                            end
                        end
                    end
                end
            end

            S_RD_WAIT: begin
                if (cnt_q == 2'd0) begin
                    data_out_d = {rom_q, 12'hFFF};
                    ack_d      = 1'b1;
                    state_d    = S_ACK;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end

            S_ACK: begin
                state_d = S_IDLE;
            end

            S_DONE: begin
                // chain is exhausted: answer everything, touch nothing but the read bus
                if (req) begin
                    ack_d = 1'b1;
                    if (rw) begin
                        data_out_d = 16'hFFFF;
                    end
                end
            end

            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_INIT;
            board_q    <= 3'd0;
            rom_a_q    <= 9'd0;
            cnt_q      <= 2'd0;
            data_out_q <= 16'hFFFF;
            ack_q      <= 1'b0;
            done_q     <= 1'b0;
            z2_base_q  <= 8'd0;
            z3_base_q  <= 16'd0;
            z3b_base_q <= 16'd0;
            z3c_base_q <= 16'd0;
            valid_q    <= 4'd0;
        end else begin
            state_q    <= state_d;
            board_q    <= board_d;
            rom_a_q    <= rom_a_d;
            cnt_q      <= cnt_d;
            data_out_q <= data_out_d;
            ack_q      <= ack_d;
            done_q     <= done_d;
            z2_base_q  <= z2_base_d;
            z3_base_q  <= z3_base_d;
            z3b_base_q <= z3b_base_d;
            z3c_base_q <= z3c_base_d;
            valid_q    <= valid_d;
        end
    end

`ifdef MINIMIG_AUTOCONFIG_ETH_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            eth_base_q  <= 16'd0;
            eth_valid_q <= 1'b0;
        end else begin
            eth_base_q  <= eth_base_d;
            eth_valid_q <= eth_valid_d;
        end
    end

    assign eth_base  = eth_base_q;
    assign cfg_valid = {eth_valid_q, valid_q};
`else
    assign eth_base  = 16'd0;
    assign cfg_valid = {1'b0, valid_q};
`endif

    assign data_out = data_out_q;
    assign ack      = ack_q;
    assign rom_a    = rom_a_q;
    assign z2_base  = z2_base_q;
    assign z3_base  = z3_base_q;
    assign z3b_base = z3b_base_q;
    assign z3c_base = z3c_base_q;
    assign board    = board_q;
    assign done     = done_q;

endmodule

// File: doc/minimig_autoconfig_ctrl.md
Name: minimig_autoconfig_ctrl

Overview:
Autoconfig bus-side controller. Consumes the 4-bit nibble autoconfig ROM (2-cycle registered read) and walks the board chain: Z2 RAM, Z3 RAM, Z3 RAM #2, Z3 RAM #3, and optionally Ethernet. It serves CPU reads of the config space from the ROM and latches the base addresses the OS writes. It also handles shut-up and exposes per-board base and valid outputs to the memory/chipset decoders.

Parameters:
ROM_LAT, 2, clocks from rom_a change to valid rom_q (1..3)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req  in  1  single-cycle config-space access request; ignored while busy
rw  in  1  1=read, 0=write (sampled with req)
reg_addr  in  7  byte offset in config space (bit0 ignored)
data_in  in  16  write data
data_out  out  16  read data; nibble in [15:12], [11:0]=FFF
ack  out  1  one-cycle completion pulse
rom_a  out  9  ROM read address {board[2:0], reg_addr[6:1]}
rom_q  in  4  ROM read data
z2_en, z3_en, z3b_en, z3c_en  in  1 each  board present in chain
z2_base  out  8  Z2 base A23..A16
z3_base, z3b_base, z3c_base, eth_base  out  16 each  Z3 base A31..A16
cfg_valid  out  5  bit n = board n configured
board  out  3  current board index (0..4, 7=end)
done  out  1  chain exhausted

Behaviour:
- States: INIT, IDLE, RD_WAIT, ACK, DONE. Board indices: 0 z2, 1 z3, 2 z3b, 3 z3c, 4 eth.
- Reset (async, reset_n=0): state INIT, board=0, rom_a=0, all bases 0, cfg_valid=0, done=0, ack=0, data_out=16'hFFFF. A reset mid-access aborts it; no ack is issued.
- INIT (one cycle after release): board=first enabled index. If none is enabled: board=7, done=1, go to DONE.
- IDLE read: at req edge, rom_a<={board,reg_addr[6:1]} and a counter loads ROM_LAT; RD_WAIT counts down. On expiry, data_out<={rom_q,12'hFFF} and ack=1 for one cycle. With ROM_LAT=2, ack is high in the 4th cycle after the req edge (req edge +3 edges). The controller never inverts data; the ROM holds bus-ready nibbles.
- IDLE write: ack one cycle after req. Decode by reg_addr[6:1]:
  - $48 on board 0: z2_base<=data_in[15:8], cfg_valid[0]<=1, advance.
  - $44 on boards 1..4: that board's base<=data_in, valid bit set, advance.
  - $4C (any board): shut-up; valid stays 0, base stays 0, advance.
  - $4A and all other offsets: ack only, no state change.
- Advance: board<=next higher enabled index. If there is none, board=7 and done=1, entering DONE in the same edge as ack.
- DONE: reads ack after 1 cycle with data_out=16'hFFFF, no ROM access, rom_a held. Writes are acked and ignored. Exit only via reset.
- req asserted while not in IDLE/DONE: ignored. The host waits for ack.
- data_out holds its last value between reads. Writes do not alter it.
- Enables are sampled only in INIT and at each advance. Changes elsewhere have no effect on the current board.

Optional Feature:
MINIMIG_AUTOCONFIG_ETH_EN
- Defined: board 4 (Ethernet) takes part in the chain as described; eth_base and cfg_valid[4] are live.
- Undefined: board 4 is always skipped (advance from the last RAM board goes to DONE), eth_base is constant 0, and cfg_valid[4] is constant 0.

Test Plan:
- All enables=1; read $00 with ROM model returning 4'hE at address 0 -> data_out=16'hEFFF, ack exactly 3 edges after req edge, rom_a=9'h000.
- Write $48 data_in=16'h2000 on board 0 -> ack next cycle, z2_base=8'h20, cfg_valid=5'b00001, board=1; subsequent read $10 drives rom_a=9'h048.
- z3b_en=0; write $44 data_in=16'h4000 on board 1 -> z3_base=16'h4000, cfg_valid[1]=1, board=3 (board 2 skipped).
- On board 3, write $4C -> cfg_valid[3]=0, z3c_base=0. With macro: board=4. Without macro: board=7, done=1.
- In DONE, read any offset -> ack after 1 cycle, data_out=16'hFFFF, rom_a unchanged; write $44 -> all bases unchanged.
- Assert reset_n=0 one cycle after a read req -> no ack, all outputs at reset values. After release with z2_en=0, z3_en=1 -> board=1.
